mac_accum_engine: RTL and testbench
===================================

# mac_accum_engine

Multiply-accumulate datapath sitting directly behind the mac_core AXI4-Lite register slave. The register slave decodes software writes into operand pairs and control pulses, which this block consumes over a valid/ready stream. The block accumulates a programmed number of signed products. It then returns the accumulator, count and status for software readback through the same register slave.

## Interface
- DATA_WIDTH, 32, operand width (signed two's complement)
- ACC_WIDTH, 64, accumulator width; must be >= 2*DATA_WIDTH
- CNT_WIDTH, 8, width of product count / length

- ACLK  in  1  clock, all state on rising edge
- ARESET  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; begins a job of len products
- clr  in  1  single-cycle synchronous abort/clear
- len  in  CNT_WIDTH  products per job, sampled on start
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts operand pair
- in_a, in_b  in  DATA_WIDTH each  signed operands
- acc_out  out  ACC_WIDTH  accumulator value
- count  out  CNT_WIDTH  products accumulated this job
- busy  out  1  state is RUN or DRAIN
- done  out  1  job complete, level, held in DONE
- ovf  out  1  sticky signed accumulator overflow for current job

## Operation
- Reset (ARESET high, asynchronous): state IDLE; acc_out=0, count=0, busy=0, done=0, ovf=0, in_ready=0; pipeline valid bits cleared.
- States:
  - IDLE: in_ready=0.
  - RUN: in_ready=1 while issued<len.
  - DRAIN: in_ready=0; waits for both pipe stages empty.
  - DONE: done=1.
- Transitions:
  - IDLE/DONE + start, len!=0 → RUN; acc, count, ovf, issued cleared in the same edge.
  - IDLE/DONE + start, len==0 → DONE; acc=0, count=0.
  - RUN: on the edge where issued reaches len → DRAIN.
  - DRAIN: final accumulate edge → DONE.
  - start in RUN/DRAIN is ignored.
  - clr in any state → IDLE; acc, count, ovf cleared; pipe flushed. clr beats start in the same cycle.
- Handshake: transfer when in_valid&&in_ready. in_a/in_b are sampled only on transfer. in_ready is registered, with no combinational path from in_valid. Upstream may hold in_valid with in_ready low indefinitely.
- Arithmetic:
  - Product is a full 2*DATA_WIDTH signed value, sign-extended to ACC_WIDTH.
  - Accumulate wraps two's-complement.
  - ovf sets when both addends have equal sign and the sum sign differs. It stays set until the next start or clr.
  - count increments per accumulate; it does not wrap, since len limits it.

## Timing
- Pipeline: transfer at edge k → operand regs at k → product reg at k+1 → acc_out/count update at k+2.
- Throughput is one product per cycle, back-to-back.
- done rises at the same edge as the final accumulate (k+2 for the last transfer); busy falls at that edge.
- len==0 job: done high one cycle after start.
- clr: effective at the next edge; products in flight are discarded.
- ARESET mid-job: immediate asynchronous return to reset values; no partial update after release.

## Structure
- Shared package mac_core_pkg holds:
  - state enum (IDLE, RUN, DRAIN, DONE)
  - default width constants DATA_WIDTH/ACC_WIDTH/CNT_WIDTH
  - function for signed-overflow detect
- Sub-module mac_pipe contains:
  - operand regs, product reg, accumulator, count and ovf
  - stage valid bits
  - flush input
- The top level holds the FSM, issued counter and handshake.

## Test plan
- Basic accumulate: len=4, pairs (1,2),(3,4),(5,6),(7,8) back-to-back → acc_out=100, count=4, done=1, ovf=0; done at edge 2 after last transfer.
- Signed products: len=2, (-3,7),(2,-5) → acc_out=0xFFFFFFFFFFFFFFE1 (-31), ovf=0.
- Stalls/backpressure: len=3, in_valid toggled randomly, 5 pairs offered → only first 3 consumed; in_ready low from edge after 3rd transfer; 4th pair still pending upstream.
- Overflow: len=2, both pairs (0x80000000,0x80000000) → acc_out=0x8000000000000000, ovf=1; next start clears ovf.
- Abort: len=4, clr after 2 transfers → next cycle state IDLE, acc_out=0, count=0, in_ready=0. Following start len=1 with (9,9) → acc_out=81, done.
- Edge cases:
  - len=0 → done one cycle after start, acc_out=0.
  - start with clr same cycle → stays IDLE.
  - ARESET pulse during DRAIN → all outputs 0 asynchronously, before the next ACLK edge.

Source files
------------

// File: rtl/mac_core_pkg.sv
// Shared types, default widths and helpers for the mac_core datapath.
package mac_core_pkg;

  localparam int unsigned MAC_DATA_WIDTH = 32;
  localparam int unsigned MAC_ACC_WIDTH  = 64;
  localparam int unsigned MAC_CNT_WIDTH  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Two's-complement add overflow: equal-sign addends with a differing sum sign.
  function automatic logic signed_add_ovf(input logic a_msb, input logic b_msb,
                                          input logic sum_msb);
    return (a_msb == b_msb) && (sum_msb != a_msb);
  endfunction

endpackage

// File: rtl/mac_pipe.sv
// Two-stage multiply pipeline feeding a wrapping signed accumulator with
// product count and sticky overflow.
module mac_pipe
  import mac_core_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MAC_DATA_WIDTH,
  parameter int unsigned ACC_WIDTH  = MAC_ACC_WIDTH,
  parameter int unsigned CNT_WIDTH  = MAC_CNT_WIDTH
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  flush,
  input  logic                  clear,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic [ACC_WIDTH-1:0]  acc_out,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  ovf,
  output logic                  op_valid,
  output logic                  prod_valid
);

  localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;

  logic signed [DATA_WIDTH-1:0] a_q;
  logic signed [DATA_WIDTH-1:0] b_q;
  logic signed [PROD_WIDTH-1:0] prod_q;
  logic signed [ACC_WIDTH-1:0]  prod_ext;
  logic signed [ACC_WIDTH-1:0]  sum;

  assign prod_ext = ACC_WIDTH'(prod_q);
  assign sum      = $signed(acc_out) + prod_ext;

  // Operand and product stages; flush drops anything in flight.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      a_q        <= '0;
      b_q        <= '0;
      prod_q     <= '0;
      op_valid   <= 1'b0;
      prod_valid <= 1'b0;
    end else if (flush) begin
      op_valid   <= 1'b0;
      prod_valid <= 1'b0;
    end else begin
      op_valid   <= load;
      prod_valid <= op_valid;
      if (load) begin
        a_q <= $signed(in_a);
        b_q <= $signed(in_b);
      end
      if (op_valid) begin
        prod_q <= PROD_WIDTH'(a_q) * PROD_WIDTH'(b_q);
      end
    end
  end

  // Accumulator, count and sticky overflow.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      acc_out <= '0;
      count   <= '0;
      ovf     <= 1'b0;
    end else if (flush || clear) begin
      acc_out <= '0;
      count   <= '0;
      ovf     <= 1'b0;
    end else if (prod_valid) begin
      acc_out <= sum;
      count   <= count + CNT_WIDTH'(1);
      ovf     <= ovf | signed_add_ovf(acc_out[ACC_WIDTH-1], prod_ext[ACC_WIDTH-1],
                                      sum[ACC_WIDTH-1]);
    end
  end

endmodule

// File: rtl/mac_accum_engine.sv
// Job sequencer for the MAC datapath: accepts len operand pairs per start,
// then waits for the pipe to drain and reports done.
module mac_accum_engine
  import mac_core_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MAC_DATA_WIDTH,
  parameter int unsigned ACC_WIDTH  = MAC_ACC_WIDTH,
  parameter int unsigned CNT_WIDTH  = MAC_CNT_WIDTH
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  start,
  input  logic                  clr,
  input  logic [CNT_WIDTH-1:0]  len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic [ACC_WIDTH-1:0]  acc_out,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf
);

  state_t               state;
  logic [CNT_WIDTH-1:0] issued;
  logic [CNT_WIDTH-1:0] issued_nxt;
  logic [CNT_WIDTH-1:0] len_q;
  logic                 xfer;
  logic                 job_clear;
  logic                 op_valid;
  logic                 prod_valid;

  assign xfer       = in_valid && in_ready;
  assign issued_nxt = issued + CNT_WIDTH'(1);
  assign job_clear  = start && !clr && ((state == IDLE) || (state == DONE));

  // Sequencer with registered handshake and status outputs; clr wins over start.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state    <= IDLE;
      issued   <= '0;
      len_q    <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (clr) begin
      state    <= IDLE;
      issued   <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            len_q  <= len;
            issued <= '0;
            if (len != '0) begin
              state    <= RUN;
              in_ready <= 1'b1;
              busy     <= 1'b1;
              done     <= 1'b0;
            end else begin
              state    <= DONE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end
          end
        end
        RUN: begin
          if (xfer) begin
            issued <= issued_nxt;
            if (issued_nxt == len_q) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // The last product is in the product stage once the operand stage empties.
          if (!op_valid) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

  mac_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_pipe (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .flush      (clr),
    .clear      (job_clear),
    .load       (xfer),
    .in_a       (in_a),
    .in_b       (in_b),
    .acc_out    (acc_out),
    .count      (count),
    .ovf        (ovf),
    .op_valid   (op_valid),
    .prod_valid (prod_valid)
  );

endmodule

// File: tb/tb_mac_accum_engine.sv
// Directed self-checking bench for mac_accum_engine.
module tb_mac_accum_engine;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        start;
  logic        clr;
  logic [7:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [63:0] acc_out;
  logic [7:0]  count;
  logic        busy;
  logic        done;
  logic        ovf;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] a_vec [8];
  logic [31:0] b_vec [8];

  mac_accum_engine dut (
    .ACLK     (ACLK),
    .ARESET   (ARESET),
    .start    (start),
    .clr      (clr),
    .len      (len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .acc_out  (acc_out),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .ovf      (ovf)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_start(input logic [7:0] l);
    len   = l;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offer a_vec/b_vec pairs until n are accepted; returns just after the last transfer edge.
  task automatic feed(input int n, input bit rnd);
    int  idx = 0;
    int  cyc = 0;
    bit  took;
    while (idx < n && cyc < 200) begin
      in_a     = a_vec[idx];
      in_b     = b_vec[idx];
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      took     = in_valid && in_ready;
      tick();
      if (took) idx++;
      cyc++;
    end
    if (idx < n) check("feed_timeout", 64'(idx), 64'(n));
    in_valid = 1'b0;
  endtask

  initial begin
    ARESET = 1'b1; start = 1'b0; clr = 1'b0; len = '0;
    in_valid = 1'b0; in_a = '0; in_b = '0;
    tick(); tick();
    ARESET = 1'b0;
    tick();
    check("rst_acc", acc_out, 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_flags", {60'd0, busy, done, ovf, in_ready}, 64'd0);

    // Basic accumulate: 1*2+3*4+5*6+7*8 = 100
    a_vec[0] = 1; b_vec[0] = 2; a_vec[1] = 3; b_vec[1] = 4;
    a_vec[2] = 5; b_vec[2] = 6; a_vec[3] = 7; b_vec[3] = 8;
    do_start(8'd4);
    check("run_ready", 64'(in_ready), 64'd1);
    check("run_busy", 64'(busy), 64'd1);
    feed(4, 1'b0);
    check("basic_ready_low", 64'(in_ready), 64'd0);
    tick();
    check("basic_done_k1", 64'(done), 64'd0);
    tick();
    check("basic_done_k2", 64'(done), 64'd1);
    check("basic_busy", 64'(busy), 64'd0);
    check("basic_acc", acc_out, 64'd100);
    check("basic_count", 64'(count), 64'd4);
    check("basic_ovf", 64'(ovf), 64'd0);

    // Signed products: -21 + -10 = -31
    a_vec[0] = 32'hFFFF_FFFD; b_vec[0] = 32'd7;
    a_vec[1] = 32'd2;         b_vec[1] = 32'hFFFF_FFFB;
    do_start(8'd2);
    feed(2, 1'b0);
    tick(); tick();
    check("signed_acc", acc_out, 64'hFFFF_FFFF_FFFF_FFE1);
    check("signed_ovf", 64'(ovf), 64'd0);
    check("signed_done", 64'(done), 64'd1);

    // Backpressure: only 3 of 5 offered pairs consumed, 1+4+9 = 14
    for (int i = 0; i < 5; i++) begin
      a_vec[i] = 32'(i + 1);
      b_vec[i] = 32'(i + 1);
    end
    do_start(8'd3);
    feed(3, 1'b1);
    in_a = a_vec[3]; in_b = b_vec[3]; in_valid = 1'b1;
    check("stall_ready_low", 64'(in_ready), 64'd0);
    tick(); tick();
    check("stall_acc", acc_out, 64'd14);
    check("stall_count", 64'(count), 64'd3);
    check("stall_done", 64'(done), 64'd1);
    tick(); tick(); tick();
    check("stall_pending_count", 64'(count), 64'd3);
    check("stall_pending_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;

    // Overflow: 2^62 + 2^62 wraps negative
    a_vec[0] = 32'h8000_0000; b_vec[0] = 32'h8000_0000;
    a_vec[1] = 32'h8000_0000; b_vec[1] = 32'h8000_0000;
    do_start(8'd2);
    feed(2, 1'b0);
    tick(); tick();
    check("ovf_acc", acc_out, 64'h8000_0000_0000_0000);
    check("ovf_flag", 64'(ovf), 64'd1);
    a_vec[0] = 32'd1; b_vec[0] = 32'd1;
    do_start(8'd1);
    check("ovf_cleared_by_start", 64'(ovf), 64'd0);
    check("start_clears_acc", acc_out, 64'd0);
    feed(1, 1'b0);
    tick(); tick();
    check("one_acc", acc_out, 64'd1);

    // Abort after 2 transfers, transfer on the clr edge is discarded
    for (int i = 0; i < 4; i++) begin
      a_vec[i] = 32'd10;
      b_vec[i] = 32'd10;
    end
    do_start(8'd4);
    feed(2, 1'b0);
    clr = 1'b1; in_valid = 1'b1; in_a = 32'd10; in_b = 32'd10;
    tick();
    clr = 1'b0; in_valid = 1'b0;
    check("clr_flags", {60'd0, busy, done, ovf, in_ready}, 64'd0);
    check("clr_acc", acc_out, 64'd0);
    check("clr_count", 64'(count), 64'd0);
    tick(); tick(); tick();
    check("clr_no_late_acc", acc_out, 64'd0);
    a_vec[0] = 32'd9; b_vec[0] = 32'd9;
    do_start(8'd1);
    feed(1, 1'b0);
    tick(); tick();
    check("post_clr_acc", acc_out, 64'd81);
    check("post_clr_done", 64'(done), 64'd1);

    // len == 0: done one cycle after start
    do_start(8'd0);
    check("len0_done", 64'(done), 64'd1);
    check("len0_acc", acc_out, 64'd0);
    check("len0_busy", 64'(busy), 64'd0);

    // start with clr: stays idle
    clr = 1'b1;
    do_start(8'd3);
    clr = 1'b0;
    check("start_clr_flags", {60'd0, busy, done, ovf, in_ready}, 64'd0);
    tick();
    check("start_clr_idle", {60'd0, busy, done, ovf, in_ready}, 64'd0);

    // Asynchronous reset while draining
    a_vec[0] = 32'd10; b_vec[0] = 32'd10;
    a_vec[1] = 32'd10; b_vec[1] = 32'd10;
    do_start(8'd2);
    feed(2, 1'b0);
    tick();
    check("drain_busy", 64'(busy), 64'd1);
    check("drain_partial_acc", acc_out, 64'd100);
    ARESET = 1'b1;
    #1;
    check("areset_acc", acc_out, 64'd0);
    check("areset_count", 64'(count), 64'd0);
    check("areset_flags", {60'd0, busy, done, ovf, in_ready}, 64'd0);
    tick();
    ARESET = 1'b0;
    tick(); tick(); tick();
    check("post_rst_acc", acc_out, 64'd0);
    check("post_rst_flags", {60'd0, busy, done, ovf, in_ready}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
